// File: rtl/gate_vector_driver.sv
// gate_vector_driver: drives every input combination of a WIDTH-input gate,
// holds each one for HOLD cycles and samples the gate's response on the last
// cycle of the hold. The response is checked against the AND of the vector,
// and mismatches are counted into a saturating counter. When mon_en is high
// on the sample cycle, a one-cycle log strobe carries the vector, the sampled
// response and the mismatch flag to a downstream recorder.
//
// Optional feature: define GATE_DRV_STOP_ON_ERR_EN to end the sweep at the
// first checked mismatch. Without it every sweep covers all 2^WIDTH vectors.
module gate_vector_driver #(
    parameter int WIDTH = 2,
    parameter int HOLD  = 10,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mon_en,
    input  logic             dut_y,
    output logic [WIDTH-1:0] vec_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             log_valid,
    output logic [WIDTH-1:0] log_vec,
    output logic             log_y,
    output logic             log_err
);

    // Hold counter only needs to reach HOLD-1; keep at least one bit for HOLD = 1.
    localparam int               HC_W      = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD - 1);
    localparam logic [WIDTH-1:0] VEC_LAST  = {WIDTH{1'b1}};
    localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    logic [HC_W-1:0] r_hold_cnt;

    logic             w_sample;
    logic             w_check;
    logic             w_mismatch;
    logic             w_last;
    logic             w_stop;
    logic [ERR_W-1:0] w_err_next;

    // Saturating +1 for the mismatch counter.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == ERR_MAX) ? v : v + ERR_W'(1);
    endfunction

    // Sample-cycle decode, mismatch against the AND reference, and sweep end.
    always_comb begin
        w_sample   = (r_state == S_DRIVE) && (r_hold_cnt == HOLD_LAST);
        w_check    = w_sample && mon_en;
        w_mismatch = (dut_y != (&vec_out));
        w_last     = (vec_out == VEC_LAST);
        w_err_next = (w_check && w_mismatch) ? sat_inc(err_cnt) : err_cnt;
`ifdef GATE_DRV_STOP_ON_ERR_EN
        w_stop     = w_last || (w_check && w_mismatch);
`else
        w_stop     = w_last;
`endif
    end

    // Sweep FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_hold_cnt <= '0;
            vec_out    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            log_valid  <= 1'b0;
            log_vec    <= '0;
            log_y      <= 1'b0;
            log_err    <= 1'b0;
        end else begin
            log_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state    <= S_DRIVE;
                        r_hold_cnt <= '0;
                        vec_out    <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_cnt    <= '0;
                    end
                end
                S_DRIVE: begin
                    if (w_sample) begin
                        r_hold_cnt <= '0;
                        err_cnt    <= w_err_next;
                        if (w_check) begin
                            log_valid <= 1'b1;
                            log_vec   <= vec_out;
                            log_y     <= dut_y;
                            log_err   <= w_mismatch;
                        end
                        if (w_stop) begin
                            r_state <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= (w_err_next == '0);
                        end else begin
                            vec_out <= vec_out + WIDTH'(1);
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HC_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_vector_driver.sv
// Bench for gate_vector_driver: a default instance (WIDTH=2, HOLD=10) swept
// against several gate models, and a WIDTH=3/HOLD=1/ERR_W=2 instance for
// counter saturation. Expected values come from a per-cycle model built on
// vector index = cycle / HOLD and phase = cycle % HOLD.
module tb_gate_vector_driver;

    localparam int W  = 2;
    localparam int H  = 10;
    localparam int E  = 8;
    localparam int NV = 1 << W;
    localparam int W3 = 3;
    localparam int E3 = 2;

`ifdef GATE_DRV_STOP_ON_ERR_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic start, mon_en, dut_y;
    logic [W-1:0] vec_out, log_vec;
    logic busy, done, pass, log_valid, log_y, log_err;
    logic [E-1:0] err_cnt;

    logic b_start, b_mon, b_y;
    logic [W3-1:0] b_vec_out, b_log_vec;
    logic b_busy, b_done, b_pass, b_log_valid, b_log_y, b_log_err;
    logic [E3-1:0] b_err_cnt;

    int errors = 0;
    int checks = 0;
    int mode   = 0;          // 0 AND, 1 stuck-at-1, 2 OR, 3 random table
    logic [NV-1:0] rnd_resp = '0;

    always #5 clk = ~clk;

    // Gate under test for the default instance.
    always_comb begin
        case (mode)
            0:       dut_y = &vec_out;
            1:       dut_y = 1'b1;
            2:       dut_y = |vec_out;
            default: dut_y = rnd_resp[vec_out];
        endcase
    end

    assign b_y = 1'b1;

    gate_vector_driver #(.WIDTH(W), .HOLD(H), .ERR_W(E)) u_dut (
        .clk(clk), .rst(rst), .start(start), .mon_en(mon_en), .dut_y(dut_y),
        .vec_out(vec_out), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .log_valid(log_valid), .log_vec(log_vec),
        .log_y(log_y), .log_err(log_err)
    );

    gate_vector_driver #(.WIDTH(W3), .HOLD(1), .ERR_W(E3)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .mon_en(b_mon), .dut_y(b_y),
        .vec_out(b_vec_out), .busy(b_busy), .done(b_done), .pass(b_pass),
        .err_cnt(b_err_cnt), .log_valid(b_log_valid), .log_vec(b_log_vec),
        .log_y(b_log_y), .log_err(b_log_err)
    );

    // Reference gate response for vector v under the current mode.
    function automatic logic model_y(input int m, input int v);
        case (m)
            0:       return (v == NV - 1);
            1:       return 1'b1;
            2:       return (v != 0);
            default: return rnd_resp[v];
        endcase
    endfunction

    // Starts a sweep and checks every DRIVE cycle until the model says DONE.
    task automatic run_sweep(input int m, input logic [NV-1:0] mon_tbl,
                             input bit hold_start, input string nm);
        int  exp_err = 0;
        bit  fin = 0;
        int  v, ph;
        bit  chk, mism;
        mode = m;
        @(negedge clk);
        start  = 1'b1;
        mon_en = 1'b0;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        checks++;
        if ({busy, done, pass, vec_out, err_cnt, log_valid} !== {1'b1, 1'b0, 1'b0, {W{1'b0}}, {E{1'b0}}, 1'b0}) begin
            errors++;
            $display("FAIL %s start: busy/done/pass/vec/err/lv=%b%b%b/%0d/%0d/%b required 100/0/0/0",
                     nm, busy, done, pass, vec_out, err_cnt, log_valid);
        end
        for (int c = 0; c < NV * H + 4 && !fin; c++) begin
            v  = c / H;
            ph = c % H;
            @(negedge clk);
            mon_en = (ph == H - 1) ? mon_tbl[v] : 1'($urandom);
            @(posedge clk); #1;
            chk  = (ph == H - 1) && mon_en;
            mism = (model_y(m, v) != (v == NV - 1));
            if (chk && mism) exp_err = (exp_err + 1 > (1 << E) - 1) ? (1 << E) - 1 : exp_err + 1;
            fin = (ph == H - 1) && ((v == NV - 1) || (STOP && chk && mism));
            checks++;
            if (log_valid !== chk) begin
                errors++;
                $display("FAIL %s log_valid c=%0d: got %b required %b", nm, c, log_valid, chk);
            end
            if (chk) begin
                checks++;
                if ({log_vec, log_y, log_err} !== {W'(v), model_y(m, v), mism}) begin
                    errors++;
                    $display("FAIL %s log c=%0d: vec/y/err=%0d/%b/%b required %0d/%b/%b",
                             nm, c, log_vec, log_y, log_err, v, model_y(m, v), mism);
                end
            end
            checks++;
            if (err_cnt !== E'(exp_err)) begin
                errors++;
                $display("FAIL %s err_cnt c=%0d: got %0d required %0d", nm, c, err_cnt, exp_err);
            end
            checks++;
            if (fin) begin
                if ({busy, done, pass, vec_out} !== {1'b0, 1'b1, (exp_err == 0), W'(v)}) begin
                    errors++;
                    $display("FAIL %s done c=%0d: busy/done/pass/vec=%b%b%b/%0d required 01%b/%0d",
                             nm, c, busy, done, pass, vec_out, (exp_err == 0), v);
                end
            end else if ({busy, done, vec_out} !== {1'b1, 1'b0, W'((c + 1) / H)}) begin
                errors++;
                $display("FAIL %s drive c=%0d: busy/done/vec=%b%b/%0d required 10/%0d",
                         nm, c, busy, done, vec_out, (c + 1) / H);
            end
        end
        if (!fin) begin
            errors++;
            $display("FAIL %s timeout: sweep model never reached done", nm);
        end
        if (!hold_start) begin
            @(posedge clk); #1;
            checks++;
            if ({log_valid, busy, done} !== 3'b001) begin
                errors++;
                $display("FAIL %s after_done: lv/busy/done=%b%b%b required 001", nm, log_valid, busy, done);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mon_en = 1'b0; b_start = 1'b0; b_mon = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({vec_out, busy, done, pass, err_cnt, log_valid, log_vec, log_y, log_err} !== '0) begin
            errors++;
            $display("FAIL reset_a: vec=%0d busy=%b done=%b pass=%b err=%0d lv=%b required all 0",
                     vec_out, busy, done, pass, err_cnt, log_valid);
        end
        checks++;
        if ({b_vec_out, b_busy, b_done, b_pass, b_err_cnt, b_log_valid, b_log_vec, b_log_y, b_log_err} !== '0) begin
            errors++;
            $display("FAIL reset_b: vec=%0d busy=%b err=%0d required all 0", b_vec_out, b_busy, b_err_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_and_sweep();
        run_sweep(0, 4'b1111, 1'b0, "and");
    endtask

    task automatic test_mon_gate();
        run_sweep(1, 4'b1001, 1'b0, "mon_gate");
    endtask

    task automatic test_or_gate();
        run_sweep(2, 4'b1111, 1'b0, "or");
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            rnd_resp = NV'($urandom);
            run_sweep(3, NV'($urandom), 1'b0, "random");
        end
    endtask

    task automatic test_async_reset();
        mode = 1;
        @(negedge clk);
        start = 1'b1; mon_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        checks++;
        if (err_cnt !== E'(1)) begin
            errors++;
            $display("FAIL areset_pre: err_cnt=%0d required 1", err_cnt);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({vec_out, busy, done, pass, err_cnt, log_valid, log_vec, log_y, log_err} !== '0) begin
            errors++;
            $display("FAIL areset_async: vec=%0d busy=%b err=%0d logy=%b loge=%b required all 0",
                     vec_out, busy, err_cnt, log_y, log_err);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({log_valid, busy, done} !== 3'b000) begin
                errors++;
                $display("FAIL areset_idle c=%0d: lv/busy/done=%b%b%b required 000", c, log_valid, busy, done);
            end
        end
        run_sweep(0, 4'b1111, 1'b0, "after_reset");
    endtask

    task automatic test_start_held();
        run_sweep(1, 4'b1111, 1'b1, "start_held");
        @(posedge clk); #1;
        checks++;
        if ({busy, done, pass, vec_out, err_cnt} !== {1'b1, 1'b0, 1'b0, {W{1'b0}}, {E{1'b0}}}) begin
            errors++;
            $display("FAIL restart: busy/done/pass/vec/err=%b%b%b/%0d/%0d required 100/0/0",
                     busy, done, pass, vec_out, err_cnt);
        end
        @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_saturation();
        int  exp_err = 0;
        bit  fin = 0;
        bit  mism;
        @(negedge clk);
        b_start = 1'b1; b_mon = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        for (int c = 0; c < 12 && !fin; c++) begin
            @(posedge clk); #1;
            mism = (c != 7);
            if (mism) exp_err = (exp_err + 1 > 3) ? 3 : exp_err + 1;
            fin = (c == 7) || (STOP && mism);
            checks++;
            if ({b_log_valid, b_log_vec, b_log_y, b_log_err, b_err_cnt} !== {1'b1, W3'(c), 1'b1, mism, E3'(exp_err)}) begin
                errors++;
                $display("FAIL sat c=%0d: lv/vec/y/e/err=%b/%0d/%b/%b/%0d required 1/%0d/1/%b/%0d",
                         c, b_log_valid, b_log_vec, b_log_y, b_log_err, b_err_cnt, c, mism, exp_err);
            end
            checks++;
            if ({b_busy, b_done, b_pass} !== (fin ? 3'b010 : 3'b100)) begin
                errors++;
                $display("FAIL sat_state c=%0d: busy/done/pass=%b%b%b required %b",
                         c, b_busy, b_done, b_pass, fin ? 3'b010 : 3'b100);
            end
        end
        if (!fin) begin
            errors++;
            $display("FAIL sat timeout: sweep never finished");
        end
    endtask

    initial begin
        test_reset();
        test_and_sweep();
        test_mon_gate();
        test_or_gate();
        test_random();
        test_async_reset();
        test_start_held();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gate_vector_driver.md
Name: gate_vector_driver

Overview:
- Synthesizable stimulus-and-check stage that sits directly upstream of a combinational gate under test: it drives every input combination, holds each for a fixed number of cycles, and samples the gate's response.
- Checks the response against an expected AND-reduction and counts mismatches.
- A runtime monitor gate suppresses checking and logging for selected vectors.
- Produces a per-vector log strobe for a downstream recorder, plus a final pass/done status.

Parameters:
- WIDTH, 2, number of gate inputs driven; legal range 1..8.
- HOLD, 10, cycles each vector is held; legal range >= 1.
- ERR_W, 8, width of the mismatch counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level-sampled; begins a sweep when in IDLE or DONE.
- mon_en  input  1  monitor gate: 1 = check and log the current vector; 0 = drive only.
- dut_y  input  1  response from the gate under test (combinational from vec_out).
- vec_out  output  WIDTH  stimulus vector to the gate under test.
- busy  output  1  high while sweeping.
- done  output  1  high after a sweep completes; stays high until the next start or reset.
- pass  output  1  valid when done = 1; high iff err_cnt == 0.
- err_cnt  output  ERR_W  number of checked mismatches; saturates at all-ones.
- log_valid  output  1  one-cycle strobe per checked vector.
- log_vec  output  WIDTH  vector associated with log_valid.
- log_y  output  1  sampled dut_y associated with log_valid.
- log_err  output  1  high with log_valid when the sampled value mismatched.

Behaviour:
- Reset (async, any state): state = IDLE; all outputs 0, including vec_out, err_cnt and log_*. Internal hold counter = 0.
- States: IDLE, DRIVE, DONE.
- IDLE or DONE with start = 1 at an edge:
  - next state DRIVE; busy = 1; done = 0; pass = 0.
  - err_cnt = 0; vec_out = 0; hold_cnt = 0.
- DRIVE:
  - hold_cnt increments each cycle; vec_out is stable for exactly HOLD cycles.
  - On the cycle where hold_cnt == HOLD-1 (the sample cycle), compare dut_y against expected = &vec_out.
  - If mon_en = 1 on the sample cycle, the next edge sets:
    - log_valid = 1, log_vec = vec_out, log_y = dut_y, log_err = mismatch.
    - err_cnt += mismatch, saturating.
  - If mon_en = 0 on the sample cycle: no log strobe and no count change. mon_en is sampled only on the sample cycle.
  - At the same edge:
    - hold_cnt returns to 0.
    - If vec_out < 2^WIDTH-1: vec_out increments.
    - Otherwise: state = DONE, busy = 0, done = 1, and pass = (final err_cnt, including this sample) == 0. vec_out holds its last value.
- log_valid is a single-cycle pulse and returns to 0 on the following edge. log_vec, log_y and log_err hold their last values.
- start while in DRIVE is ignored; a sweep cannot be restarted mid-way except by rst.
- Sweep length: exactly 2^WIDTH * HOLD cycles in DRIVE. With the defaults: 40 cycles, 4 log strobes when mon_en is held high.
- Timing examples:
  - HOLD = 1: every DRIVE cycle is a sample cycle.
  - HOLD = 10: sampling occurs 9 cycles after the vector is applied.

Optional Feature:
- Macro: GATE_DRV_STOP_ON_ERR_EN.
- Defined: the first checked mismatch ends the sweep at that sample edge. State goes to DONE; done = 1, pass = 0, err_cnt = 1; the log strobe still fires for the failing vector.
- Undefined: the sweep always covers all 2^WIDTH vectors regardless of mismatches.

Test Plan:
- Correct AND DUT, defaults, mon_en = 1, start pulse → 4 log strobes with log_vec 0,1,2,3 and log_y 0,0,0,1, spaced 10 cycles apart; done = 1 and pass = 1 after 40 DRIVE cycles; err_cnt = 0.
- mon_en = 0 for vectors 1 and 2, 1 otherwise, with the DUT stuck at 1 → strobes only for vec 0 (log_err = 1) and vec 3; err_cnt = 1; pass = 0.
- OR gate as DUT, mon_en = 1 → mismatches at vec 1 and 2; err_cnt = 2; pass = 0. With GATE_DRV_STOP_ON_ERR_EN defined: done at the vec 1 sample, err_cnt = 1, 20 DRIVE cycles.
- rst asserted at DRIVE cycle 15, then released → outputs 0 immediately (async); state IDLE; no strobes until the next start; a new start gives a full 40-cycle sweep.
- start held high through DRIVE and after DONE → no restart mid-sweep; a new sweep begins on the edge after entering DONE with start still high, and err_cnt clears.
- WIDTH = 3, HOLD = 1, ERR_W = 2, DUT stuck at 1 → 7 mismatches; err_cnt saturates at 3; 8 consecutive log strobes; done after 8 cycles.
